// File: rtl/ped_cost_unit.sv
// ped_cost_unit: partial Euclidean distance (PED) evaluator for a depth-first
// 4-level 8-PAM sphere decoder. Holds an upper-triangular R matrix, a received
// vector y and a per-level PED stack; each child cost = parent PED + e_k^2.
//
// Ports:
//   Clk, Reset            clock, synchronous active-low reset
//   LoadEn/Addr/Data      coefficient write (0..9 R00..R33 row-major upper, 10..13 y0..y3)
//   InValid/InReady       node request handshake (InReady = !LoadEn)
//   node_lvl, Sym0..Sym3  node level (3 = root side) and symbol indices
//   OutValid              one-cycle pulse, 2 edges after accept (stage1 + stage2)
//   current_node_cost     saturated PED of the returned node
//   OutLvl                level of the returned node
// Optional (macro PED_PRUNE_EN): Radius input, OutPrune output; a pruned node
// does not update its PED stack entry.
module ped_cost_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned COEF_W = 12
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     LoadEn,
  input  logic [3:0]               LoadAddr,
  input  logic signed [COEF_W-1:0] LoadData,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [1:0]               node_lvl,
  input  logic [2:0]               Sym0,
  input  logic [2:0]               Sym1,
  input  logic [2:0]               Sym2,
  input  logic [2:0]               Sym3,
`ifdef PED_PRUNE_EN
  input  logic [WIDTH-1:0]         Radius,
  output logic                     OutPrune,
`endif
  output logic                     OutValid,
  output logic [WIDTH-1:0]         current_node_cost,
  output logic [1:0]               OutLvl
);

  localparam int unsigned EW  = COEF_W + 6;
  localparam int unsigned SQW = 2 * EW;
  localparam int unsigned SW  = ((WIDTH > SQW) ? WIDTH : SQW) + 1;

  function automatic logic signed [EW-1:0] cx(input logic signed [COEF_W-1:0] c);
    return EW'(c);
  endfunction

  logic signed [COEF_W-1:0] r_q [10];
  logic signed [COEF_W-1:0] r_d [10];
  logic signed [COEF_W-1:0] y_q [4];
  logic signed [COEF_W-1:0] y_d [4];
  logic [WIDTH-1:0]         ped_q [4];
  logic [WIDTH-1:0]         ped_d [4];

  logic signed [EW-1:0] e_q, e_d;
  logic [1:0]           k_q, k_d;
  logic                 v1_q, v1_d;

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     cost_q, cost_d;
  logic [1:0]           lvl_q, lvl_d;
  logic                 prune_q, prune_d;

  logic [2:0]           sym_a [4];
  logic signed [3:0]    amp4 [4];
  logic signed [EW-1:0] amp [4];
  logic signed [EW-1:0] res [4];

  logic signed [SQW-1:0] e_wide;
  logic [SQW-1:0]        sq;
  logic [WIDTH-1:0]      parent;
  logic [SW-1:0]         sum_wide;
  logic [WIDTH-1:0]      sum;
  logic                  prune;
  logic                  accept;

  assign InReady = !LoadEn;
  assign accept  = InValid && !LoadEn;

  // Stage 1: residual of the requested level from the live coefficients.
  always_comb begin
    sym_a[0] = Sym0;
    sym_a[1] = Sym1;
    sym_a[2] = Sym2;
    sym_a[3] = Sym3;
    for (int j = 0; j < 4; j++) begin
      // a = 2i - 7 fits exactly in 4-bit two's complement
      amp4[j] = signed'(4'({sym_a[j], 1'b0} - 4'd7));
      amp[j]  = EW'(amp4[j]);
    end
    res[3] = cx(y_q[3]) - cx(r_q[9]) * amp[3];
    res[2] = cx(y_q[2]) - cx(r_q[7]) * amp[2] - cx(r_q[8]) * amp[3];
    res[1] = cx(y_q[1]) - cx(r_q[4]) * amp[1] - cx(r_q[5]) * amp[2]
           - cx(r_q[6]) * amp[3];
    res[0] = cx(y_q[0]) - cx(r_q[0]) * amp[0] - cx(r_q[1]) * amp[1]
           - cx(r_q[2]) * amp[2] - cx(r_q[3]) * amp[3];
  end

  // Stage 2: square, add parent PED, saturate.
  always_comb begin
    e_wide   = SQW'(e_q);
    sq       = e_wide * e_wide;
    parent   = (k_q == 2'd3) ? '0 : ped_q[k_q + 2'd1];
    sum_wide = SW'(parent) + SW'(sq);
    sum      = (|sum_wide[SW-1:WIDTH]) ? '1 : sum_wide[WIDTH-1:0];
`ifdef PED_PRUNE_EN
    prune    = (sum >= Radius);
`else
    prune    = 1'b0;
`endif
  end

  always_comb begin
    r_d   = r_q;
    y_d   = y_q;
    ped_d = ped_q;
    e_d   = e_q;
    k_d   = k_q;
    v1_d  = accept;
    if (accept) begin
      e_d = res[node_lvl];
      k_d = node_lvl;
    end

    valid_d = v1_q;
    cost_d  = cost_q;
    lvl_d   = lvl_q;
    prune_d = prune_q;
    if (v1_q) begin
      cost_d  = sum;
      lvl_d   = k_q;
      prune_d = prune;
      if (!prune) ped_d[k_q] = sum;
    end

    // A load starts a new frame: stack clear overrides a same-edge stack write.
    if (LoadEn) begin
      for (int i = 0; i < 4; i++) ped_d[i] = '0;
      if (LoadAddr < 4'd10) begin
        r_d[LoadAddr] = LoadData;
      end else if (LoadAddr < 4'd14) begin
        y_d[LoadAddr[1:0] + 2'd2] = LoadData;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 10; i++) r_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        y_q[i]   <= '0;
        ped_q[i] <= '0;
      end
      e_q     <= '0;
      k_q     <= '0;
      v1_q    <= 1'b0;
      valid_q <= 1'b0;
      cost_q  <= '0;
      lvl_q   <= 2'd3;
      prune_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      y_q     <= y_d;
      ped_q   <= ped_d;
      e_q     <= e_d;
      k_q     <= k_d;
      v1_q    <= v1_d;
      valid_q <= valid_d;
      cost_q  <= cost_d;
      lvl_q   <= lvl_d;
      prune_q <= prune_d;
    end
  end

  assign OutValid          = valid_q;
  assign current_node_cost = cost_q;
  assign OutLvl            = lvl_q;
`ifdef PED_PRUNE_EN
  assign OutPrune          = prune_q;
`endif

endmodule
